// File: rtl/fp_sqrt_iter.sv
// Multi-cycle IEEE-754 square root with a restoring digit-recurrence core and
// round-to-nearest-even. One operation in flight, valid/ready on both sides.
module fp_sqrt_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int XLEN = 1 + EXP_W + MAN_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            invalid,
    output logic            inexact
);

    localparam int N  = MAN_W + 2;
    localparam int RW = MAN_W + 5;
    localparam int CW = $clog2(N + 1);
    localparam logic [EXP_W-1:0] BIAS      = {1'b0, {(EXP_W-1){1'b1}}};
    localparam logic [XLEN-1:0]  QNAN      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [CW-1:0]    CALC_LAST = CW'(N - 1);
    localparam logic [CW-1:0]    SP_WAIT   = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_r;
    logic [CW-1:0]     cnt_r;
    logic [2*N-1:0]    rad_r;
    logic [RW-1:0]     rem_r;
    logic [N-1:0]      root_r;
    logic [EXP_W-1:0]  exp_r;
    logic              special_r;
    logic [XLEN-1:0]   sp_res_r;
    logic              sp_inv_r;
    logic [XLEN-1:0]   result_r;
    logic              invalid_r;
    logic              inexact_r;
    logic              out_valid_r;
    logic              in_ready_r;

    logic              sign_s;
    logic [EXP_W-1:0]  exp_f_s;
    logic [MAN_W-1:0]  man_f_s;
    logic              is_special_s;
    logic [XLEN-1:0]   sp_res_s;
    logic              sp_inv_s;
    logic [EXP_W:0]    e_s;
    logic [EXP_W-1:0]  exp_s;
    logic [N-1:0]      radicand_s;

    logic [RW-1:0]     rem_sh_s;
    logic [RW-1:0]     trial_s;
    logic              ge_s;
    logic [RW-1:0]     rem_nx_s;
    logic [N-1:0]      root_nx_s;

    logic              guard_s;
    logic              sticky_s;
    logic              round_up_s;
    logic [N-1:0]      mant_sum_s;
    logic [EXP_W-1:0]  res_exp_s;
    logic [MAN_W-1:0]  res_frac_s;
    logic [XLEN-1:0]   norm_res_s;
    logic              norm_inx_s;

    assign sign_s  = a[XLEN-1];
    assign exp_f_s = a[XLEN-2:MAN_W];
    assign man_f_s = a[MAN_W-1:0];

    // Operand classification and special-case result selection.
    always_comb begin
        is_special_s = 1'b1;
        sp_res_s     = {XLEN{1'b0}};
        sp_inv_s     = 1'b0;
        if ((&exp_f_s) && (|man_f_s)) begin
            sp_res_s = QNAN;
            sp_inv_s = ~man_f_s[MAN_W-1];
        end else if (&exp_f_s) begin
            sp_res_s = sign_s ? QNAN : a;
            sp_inv_s = sign_s;
        end else if (~|exp_f_s) begin
            // zeros and denormals both collapse to a signed zero
            sp_res_s = {sign_s, {(XLEN-1){1'b0}}};
            sp_inv_s = 1'b0;
        end else if (sign_s) begin
            sp_res_s = QNAN;
            sp_inv_s = 1'b1;
        end else begin
            is_special_s = 1'b0;
        end
    end

    // Unbiased exponent, even-exponent adjustment and halved result exponent.
    always_comb begin
        e_s   = {1'b0, exp_f_s} - {1'b0, BIAS};
        // e_s[EXP_W:1] is floor(e/2) in two's complement, valid for odd e too
        exp_s = e_s[EXP_W:1] + BIAS;
        if (e_s[0]) begin
            radicand_s = {1'b1, man_f_s, 1'b0};
        end else begin
            radicand_s = {1'b0, 1'b1, man_f_s};
        end
    end

    // One restoring root-digit step.
    always_comb begin
        rem_sh_s  = {rem_r[RW-3:0], rad_r[2*N-1 -: 2]};
        trial_s   = {1'b0, root_r, 2'b01};
        ge_s      = (rem_sh_s >= trial_s);
        if (ge_s) begin
            rem_nx_s = rem_sh_s - trial_s;
        end else begin
            rem_nx_s = rem_sh_s;
        end
        root_nx_s = {root_r[N-2:0], ge_s};
    end

    // Round-to-nearest-even on the finished root.
    always_comb begin
        guard_s    = root_r[0];
        sticky_s   = |rem_r;
        round_up_s = guard_s & (sticky_s | root_r[1]);
        mant_sum_s = {1'b0, root_r[N-1:1]} + {{(N-1){1'b0}}, round_up_s};
        if (mant_sum_s[N-1]) begin
            res_exp_s  = exp_r + EXP_W'(1);
            res_frac_s = {MAN_W{1'b0}};
        end else begin
            res_exp_s  = exp_r;
            res_frac_s = mant_sum_s[MAN_W-1:0];
        end
        norm_res_s = {1'b0, res_exp_s, res_frac_s};
        norm_inx_s = guard_s | sticky_s;
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            rad_r       <= {(2*N){1'b0}};
            rem_r       <= {RW{1'b0}};
            root_r      <= {N{1'b0}};
            exp_r       <= {EXP_W{1'b0}};
            special_r   <= 1'b0;
            sp_res_r    <= {XLEN{1'b0}};
            sp_inv_r    <= 1'b0;
            result_r    <= {XLEN{1'b0}};
            invalid_r   <= 1'b0;
            inexact_r   <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        in_ready_r <= 1'b0;
                        invalid_r  <= 1'b0;
                        inexact_r  <= 1'b0;
                        special_r  <= is_special_s;
                        sp_res_r   <= sp_res_s;
                        sp_inv_r   <= sp_inv_s;
                        exp_r      <= exp_s;
                        rad_r      <= {radicand_s, {N{1'b0}}};
                        rem_r      <= {RW{1'b0}};
                        root_r     <= {N{1'b0}};
                        if (is_special_s) begin
                            // specials idle one extra cycle in ROUND: two-edge latency
                            cnt_r   <= SP_WAIT;
                            state_r <= ST_ROUND;
                        end else begin
                            cnt_r   <= CALC_LAST;
                            state_r <= ST_CALC;
                        end
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_CALC: begin
                    rad_r  <= {rad_r[2*N-3:0], 2'b00};
                    rem_r  <= rem_nx_s;
                    root_r <= root_nx_s;
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r <= ST_ROUND;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                ST_ROUND: begin
                    if (cnt_r != {CW{1'b0}}) begin
                        cnt_r <= cnt_r - CW'(1);
                    end else begin
                        if (special_r) begin
                            result_r  <= sp_res_r;
                            invalid_r <= sp_inv_r;
                            inexact_r <= 1'b0;
                        end else begin
                            result_r  <= norm_res_s;
                            invalid_r <= 1'b0;
                            inexact_r <= norm_inx_s;
                        end
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign invalid   = invalid_r;
    assign inexact   = inexact_r;

endmodule

// File: tb/tb_fp_sqrt_iter.sv
// Randomised self-checking bench for fp_sqrt_iter (fp32), referenced against the
// host double-precision sqrt rounded to single precision.
module tb_fp_sqrt_iter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] a;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            invalid;
    logic            inexact;

    int vec_count       = 0;
    int miscompare_count = 0;

    fp_sqrt_iter #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .invalid   (invalid),
        .inexact   (inexact)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompare_count++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    // sqrt of a positive normal: double sqrt is correctly rounded, and 53 bits
    // are enough for a second RNE rounding to 24 bits to be exact.
    function automatic void ref_sqrt(input logic [31:0] x, output logic [31:0] r, output logic inx);
        logic [63:0] db;
        logic [63:0] sb;
        logic [22:0] keep;
        logic [28:0] rest;
        logic        up;
        logic [23:0] m;
        int          ex;
        real         d;
        real         s;
        db   = {1'b0, 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        d    = $bitstoreal(db);
        s    = $sqrt(d);
        sb   = $realtobits(s);
        keep = sb[51:29];
        rest = sb[28:0];
        up   = (rest > 29'h1000_0000) || ((rest == 29'h1000_0000) && keep[0]);
        m    = {1'b0, keep} + {23'd0, up};
        ex   = int'(sb[62:52]) - 1023 + 127 + int'(m[23]);
        r    = {1'b0, 8'(ex), (m[23] ? 23'd0 : m[22:0])};
        inx  = (rest != 29'd0);
    endfunction

    task automatic run_op(input string tag, input logic [31:0] op, input logic [31:0] exp_res,
                          input logic exp_inv, input logic exp_inx, input int exp_lat,
                          input int hold, input bit stress);
        int wait_cnt;
        int lat;
        @(negedge clk);
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        a        = op;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_result"}, 64'(result), 64'(exp_res));
        check_eq({tag, "_invalid"}, 64'(invalid), 64'(exp_inv));
        check_eq({tag, "_inexact"}, 64'(inexact), 64'(exp_inx));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (stress) begin
                check_eq({tag, "_bp_valid"}, 64'(out_valid), 64'd1);
                check_eq({tag, "_bp_result"}, 64'(result), 64'(exp_res));
                check_eq({tag, "_bp_inexact"}, 64'(inexact), 64'(exp_inx));
                check_eq({tag, "_bp_in_ready"}, 64'(in_ready), 64'd0);
                a        = $urandom;
                in_valid = (i % 2 == 0);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        if (stress) begin
            check_eq({tag, "_idle_in_ready"}, 64'(in_ready), 64'd1);
            check_eq({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
            repeat (4) @(negedge clk);
            check_eq({tag, "_no_ghost_op"}, 64'(out_valid), 64'd0);
        end
    endtask

    logic [31:0] sp_in  [10] = '{32'hBF800000, 32'h80000000, 32'h7F800000, 32'h00000001, 32'h00000000,
                                 32'hFF800000, 32'h7FC12345, 32'h7F800001, 32'h80000005, 32'hFFC00000};
    logic [31:0] sp_out [10] = '{32'h7FC00000, 32'h80000000, 32'h7F800000, 32'h00000000, 32'h00000000,
                                 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h80000000, 32'h7FC00000};
    logic        sp_inv [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] edge_ops [4] = '{32'h00800000, 32'h7F7FFFFF, 32'h3F800000, 32'h3F800001};

    initial begin
        logic [31:0] r;
        logic        inx;
        logic [31:0] op;
        int          n_done;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 32'd0;
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_result", 64'(result), 64'd0);
        check_eq("rst_invalid", 64'(invalid), 64'd0);
        check_eq("rst_inexact", 64'(inexact), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);

        run_op("sqrt4", 32'h40800000, 32'h40000000, 1'b0, 1'b0, 26, 0, 1'b0);
        run_op("sqrt2", 32'h40000000, 32'h3FB504F3, 1'b0, 1'b1, 26, 0, 1'b0);
        run_op("sqrt025", 32'h3E800000, 32'h3F000000, 1'b0, 1'b0, 26, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            run_op("special", sp_in[i], sp_out[i], sp_inv[i], 1'b0, 2, 0, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            ref_sqrt(edge_ops[i], r, inx);
            run_op("edge", edge_ops[i], r, 1'b0, inx, 26, 0, 1'b0);
        end

        run_op("backpressure", 32'h40000000, 32'h3FB504F3, 1'b0, 1'b1, 26, 10, 1'b1);

        // abort an operation partway through the recurrence
        @(negedge clk);
        a        = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check_eq("mid_calc_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("aborted_no_result", 64'(out_valid), 64'd0);
        run_op("sqrt9", 32'h41100000, 32'h40400000, 1'b0, 1'b0, 26, 0, 1'b0);

        n_done = 0;
        for (int i = 0; i < 1000; i++) begin
            op = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
            ref_sqrt(op, r, inx);
            run_op("random", op, r, 1'b0, inx, 26, int'($urandom_range(0, 3)), 1'b0);
            n_done++;
        end
        check_eq("random_count", 64'(n_done), 64'd1000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
        $finish;
    end

endmodule
